ucpu_fetch_sequencer: RTL
=========================

// Module: ucpu_fetch_sequencer
// PURPOSE
// Instruction fetch/issue controller for the 6-bit accumulator uProcessor. It owns
// the program counter, fetches from instruction memory via a req/ack handshake,
// holds the instruction register driving the decoder's Ins input, and issues a
// one-cycle exec_en strobe gating the decoder's Reg_CE/A_CE/CY_CE. It supports
// run, single-step, halt-request, a HALT opcode and a fetch-timeout fault.
// PARAMETERS
// PC_W        8        program counter / imem address width
// HALT_OP     4'b1111  Ins[5:2] value that stops the core (not executed)
// NOP_INS     6'b1011_00  instruction-register value after reset
// ACK_TIMEOUT 15       max FETCH cycles without imem_ack before FAULT (>=1)
// CNT_W       16       retired-instruction counter width
// PORTS
// clk        in   1      system clock, rising edge
// rst_n      in   1      synchronous active-low reset
// run        in   1      level: continuous execution while high
// step       in   1      pulse: execute exactly one instruction (from IDLE only)
// halt_req   in   1      level: stop after the current instruction retires
// imem_req   out  1      fetch request, held until imem_ack
// imem_addr  out  PC_W   fetch address (= pc), stable while imem_req high
// imem_ack   in   1      memory returns imem_data this cycle
// imem_data  in   6      fetched instruction
// ins        out  6      instruction register -> decoder Ins
// exec_en    out  1      1-cycle strobe: decoder enables valid this cycle
// pc         out  PC_W   current program counter
// retired    out  CNT_W  count of executed instructions, saturating
// busy       out  1      state is FETCH or EXEC
// halted     out  1      state is HALT (sticky)
// fault      out  1      state is FAULT (sticky)
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge, any state, incl. mid-fetch): state=IDLE, pc=0,
//   ins=NOP_INS, retired=0, timeout cnt=0; all 1-bit outputs 0.
// - States: IDLE, FETCH, EXEC, HALT, FAULT. Outputs are registered/state-decoded.
// - IDLE: run=1 and halt_req=0 -> FETCH, mode=RUN; else step=1 and halt_req=0 ->
//   FETCH, mode=STEP; run and step together -> RUN. Otherwise stay.
// - FETCH: imem_req=1, imem_addr=pc. imem_ack=1 -> ins<=imem_data, tcnt<=0, ->EXEC.
//   Ack may arrive the first FETCH cycle (zero-wait). No ack: tcnt++; when tcnt
//   reaches ACK_TIMEOUT with no ack -> FAULT. Ack on the timeout cycle wins.
// - EXEC (one cycle): if ins[5:2]==HALT_OP -> HALT, exec_en=0, pc/retired unchanged.
//   Else exec_en=1, pc<=pc+1 mod 2^PC_W (wraps to 0), retired<=retired+1
//   saturating at all-ones; next = FETCH if mode=RUN and run=1 and halt_req=0,
//   else IDLE.
// - halt_req or run deassert during FETCH: fetch completes, instruction executes,
//   then IDLE; never abandons an outstanding request.
// - step while busy is ignored (not queued).
// - HALT, FAULT: terminal until reset; imem_req=0, exec_en=0.
// - Timing: run rise in IDLE -> imem_req next cycle; zero-wait memory -> 1 instr
//   per 2 cycles; exec_en asserted exactly one cycle after the ack cycle.
// - imem_data is sampled only on ack; ins is stable outside FETCH->EXEC edge.
// TESTING
// 1 Reset mid-FETCH with imem_req=1 -> next cycle IDLE, pc=0, ins=NOP_INS, req=0.
// 2 run=1, zero-wait mem, prog 0x05,0x12,0x3C(HALT) -> exec_en pulses 2x, pc=2,
//   retired=2, halted=1, imem_req never asserts again.
// 3 step pulse, mem acks after 3 wait cycles -> one exec_en, pc 0->1, back IDLE.
// 4 No ack for 15 FETCH cycles -> fault=1 on cycle 16; ack at cycle 15 -> EXEC.
// 5 PC_W=2, run from pc=3 -> after exec pc=0, imem_addr=0 on next fetch.
// 6 halt_req rises during wait -> fetch completes, exec_en once, IDLE, busy=0.

Source files
------------

// File: rtl/ucpu_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the fetch sequencer (master) and imem (slave).
// The request is held, with a stable address, until the memory acknowledges.
interface ucpu_fetch_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [5:0]      imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/ucpu_fetch_sequencer.sv
// Fetch/issue controller for the 6-bit accumulator uProcessor: owns the PC and the
// instruction register, and strobes exec_en for one cycle per retired instruction.
module ucpu_fetch_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter logic [3:0]  HALT_OP     = 4'b1111,
  parameter logic [5:0]  NOP_INS     = 6'b1011_00,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      step,
  input  logic                      halt_req,
  ucpu_fetch_sequencer_if.master    imem,
  output logic [5:0]                ins,
  output logic                      exec_en,
  output logic [PC_W-1:0]           pc,
  output logic [CNT_W-1:0]          retired,
  output logic                      busy,
  output logic                      halted,
  output logic                      fault
);

  localparam int unsigned TCNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_e;

  typedef enum logic {
    M_RUN,
    M_STEP
  } mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [5:0]        ins_q, ins_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic is_halt_op;
  assign is_halt_op = (ins_q[5:2] == HALT_OP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= M_RUN;
      pc_q      <= '0;
      ins_q     <= NOP_INS;
      retired_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      retired_q <= retired_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // NOTE: every next-state variable is defaulted to its current value first, so
  // no path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pc_d      = pc_q;
    ins_d     = ins_q;
    retired_d = retired_q;
    tcnt_d    = tcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (run && !halt_req) begin
          state_d = S_FETCH;
          mode_d  = M_RUN;
        end else if (step && !halt_req) begin
          state_d = S_FETCH;
          mode_d  = M_STEP;
        end
      end

      S_FETCH: begin
        // An ack on the final allowed cycle still completes the fetch.
        if (imem.imem_ack) begin
          ins_d   = imem.imem_data;
          tcnt_d  = '0;
          state_d = S_EXEC;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_W'(ACK_TIMEOUT - 1)) begin
            state_d = S_FAULT;
          end
        end
      end

      S_EXEC: begin
        if (is_halt_op) begin
          state_d = S_HALT;
        end else begin
          pc_d      = pc_q + PC_W'(1);
          retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
          state_d   = (mode_q == M_RUN && run && !halt_req) ? S_FETCH : S_IDLE;
        end
      end

      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign exec_en        = (state_q == S_EXEC) && !is_halt_op;
  assign ins            = ins_q;
  assign pc             = pc_q;
  assign retired        = retired_q;
  assign busy           = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted         = (state_q == S_HALT);
  assign fault          = (state_q == S_FAULT);

endmodule
